// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, result select, load alignment
// and extension, register file write port, WB-to-EX forwarding bus and the
// retired-instruction counter.
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic             flush,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_wr,
    input  logic [1:0]       mem_wb_sel,
    input  logic [2:0]       mem_funct3,
    input  logic [XLEN-1:0]  mem_alu_res,
    input  logic [XLEN-1:0]  mem_load_data,
    input  logic [XLEN-1:0]  mem_pc4,
    output logic [4:0]       wr_reg,
    output logic [XLEN-1:0]  wr_data,
    output logic             reg_wr,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic             misalign,
    output logic [CNT_W-1:0] instret
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    // Stage register contents
    logic             valid_reg;
    logic [4:0]       rd_reg;
    logic             reg_wr_en_reg;
    logic [1:0]       wb_sel_reg;
    logic [2:0]       funct3_reg;
    logic [XLEN-1:0]  alu_res_reg;
    logic [XLEN-1:0]  load_data_reg;
    logic [XLEN-1:0]  pc4_reg;
    logic [CNT_W-1:0] instret_reg;

    // Derived combinational values
    logic [7:0]       lane [4];
    logic [1:0]       addr;
    logic [7:0]       byte_val;
    logic [15:0]      half_val;
    logic [XLEN-1:0]  load_val;
    logic             load_misaligned;
    logic [XLEN-1:0]  sel_val;
    logic             misalign_int;
    logic             retire;

    // Capture the retiring instruction from MEM; flush overrides mem_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg     <= 1'b0;
            rd_reg        <= '0;
            reg_wr_en_reg <= 1'b0;
            wb_sel_reg    <= SEL_ALU;
            funct3_reg    <= '0;
            alu_res_reg   <= '0;
            load_data_reg <= '0;
            pc4_reg       <= '0;
        end else begin
            valid_reg     <= mem_valid & ~flush;
            rd_reg        <= mem_rd;
            reg_wr_en_reg <= mem_reg_wr;
            wb_sel_reg    <= mem_wb_sel;
            funct3_reg    <= mem_funct3;
            alu_res_reg   <= mem_alu_res;
            load_data_reg <= mem_load_data;
            pc4_reg       <= mem_pc4;
        end
    end

    // Split the loaded word into byte lanes, lane 0 being the lowest byte
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = load_data_reg[8*gi +: 8];
        end
    endgenerate

    assign addr     = alu_res_reg[1:0];
    assign byte_val = lane[addr];
    assign half_val = addr[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};

    // Align/extend load data and flag misaligned halfword/word accesses
    always_comb begin
        load_val        = load_data_reg;
        load_misaligned = 1'b0;
        case (funct3_reg)
            3'b000: load_val = {{(XLEN-8){byte_val[7]}}, byte_val};
            3'b100: load_val = {{(XLEN-8){1'b0}}, byte_val};
            3'b001: begin
                load_val        = {{(XLEN-16){half_val[15]}}, half_val};
                load_misaligned = addr[0];
            end
            3'b101: begin
                load_val        = {{(XLEN-16){1'b0}}, half_val};
                load_misaligned = addr[0];
            end
            // lw and any unassigned code behave as a full-word load
            default: begin
                load_val        = load_data_reg;
                load_misaligned = (addr != 2'b00);
            end
        endcase
    end

    // Result source select; the reserved code falls back to the ALU result
    always_comb begin
        sel_val = alu_res_reg;
        case (wb_sel_reg)
            SEL_LOAD: sel_val = load_val;
            SEL_PC4:  sel_val = pc4_reg;
            default:  sel_val = alu_res_reg;
        endcase
    end

    assign misalign_int = valid_reg & (wb_sel_reg == SEL_LOAD) & load_misaligned;
    assign retire       = valid_reg & ~misalign_int;

    // Write port and forwarding bus are driven only from the stage register
    assign reg_wr    = valid_reg & reg_wr_en_reg & (rd_reg != 5'd0) & ~misalign_int;
    assign wr_reg    = valid_reg ? rd_reg  : 5'd0;
    assign wr_data   = valid_reg ? sel_val : '0;
    assign fwd_valid = reg_wr;
    assign fwd_rd    = wr_reg;
    assign fwd_data  = wr_data;
    assign misalign  = misalign_int;
    assign instret   = instret_reg;

    // Count every retired instruction, writing or not; wraps silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_reg <= '0;
        end else if (retire) begin
            instret_reg <= instret_reg + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
`timescale 1ns/1ps
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        flush;
    logic [4:0]  mem_rd;
    logic        mem_reg_wr;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_res;
    logic [31:0] mem_load_data;
    logic [31:0] mem_pc4;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic        reg_wr;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        misalign;
    logic [63:0] instret;

    int total;
    int bad;
    logic [63:0] exp_cnt;

    wb_stage #(.XLEN(32), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .flush(flush),
        .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr), .mem_wb_sel(mem_wb_sel),
        .mem_funct3(mem_funct3), .mem_alu_res(mem_alu_res),
        .mem_load_data(mem_load_data), .mem_pc4(mem_pc4),
        .wr_reg(wr_reg), .wr_data(wr_data), .reg_wr(reg_wr),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .misalign(misalign), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one MEM slot at a falling edge, let it be captured, sample 1ns later
    task automatic issue(input logic v, input logic fl, input logic [4:0] rd,
                         input logic we, input logic [1:0] sel, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc4);
        @(negedge clk);
        mem_valid = v; flush = fl; mem_rd = rd; mem_reg_wr = we; mem_wb_sel = sel;
        mem_funct3 = f3; mem_alu_res = alu; mem_load_data = ld; mem_pc4 = pc4;
        @(posedge clk);
        #1;
        $display("txn v=%0b fl=%0b rd=%0d sel=%0d f3=%0d alu=%h ld=%h -> reg_wr=%0b wr_reg=%0d wr_data=%h misalign=%0b instret=%0d",
                 v, fl, rd, sel, f3, alu, ld, reg_wr, wr_reg, wr_data, misalign, instret);
    endtask

    task automatic bubble();
        issue(1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_valid = 1'b0; flush = 1'b0; mem_rd = '0; mem_reg_wr = 1'b0;
        mem_wb_sel = '0; mem_funct3 = '0; mem_alu_res = '0; mem_load_data = '0; mem_pc4 = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({reg_wr, wr_reg, wr_data, fwd_valid, fwd_rd, fwd_data, misalign} !== 72'h0) begin
            bad++;
            $display("FAIL reset_outputs: reg_wr=%0b wr_reg=%0d wr_data=%h misalign=%0b required all zero",
                     reg_wr, wr_reg, wr_data, misalign);
        end
        total++;
        if (instret !== 64'h0) begin
            bad++; $display("FAIL reset_instret: got=%0d required=0", instret);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 64'h0;
    endtask

    task automatic test_alu_jal();
        issue(1'b1, 1'b0, 5'd5, 1'b1, 2'b00, 3'b000, 32'h1234, 32'hDEADBEEF, 32'h44);
        total++;
        if ({reg_wr, wr_reg, wr_data} !== {1'b1, 5'd5, 32'h1234}) begin
            bad++; $display("FAIL addi_write: got we=%0b rd=%0d data=%h required we=1 rd=5 data=00001234", reg_wr, wr_reg, wr_data);
        end
        total++;
        if ({fwd_valid, fwd_rd, fwd_data} !== {1'b1, 5'd5, 32'h1234}) begin
            bad++; $display("FAIL addi_fwd: got v=%0b rd=%0d data=%h required v=1 rd=5 data=00001234", fwd_valid, fwd_rd, fwd_data);
        end
        exp_cnt++;
        issue(1'b1, 1'b0, 5'd1, 1'b1, 2'b10, 3'b000, 32'h200, 32'h0, 32'h80);
        total++;
        if ({reg_wr, wr_reg, wr_data} !== {1'b1, 5'd1, 32'h80}) begin
            bad++; $display("FAIL jal_write: got we=%0b rd=%0d data=%h required we=1 rd=1 data=00000080", reg_wr, wr_reg, wr_data);
        end
        total++;
        if (instret !== 64'd1) begin
            bad++; $display("FAIL jal_instret: got=%0d required=1", instret);
        end
        exp_cnt++;
        // reserved select code behaves as the ALU result
        issue(1'b1, 1'b0, 5'd6, 1'b1, 2'b11, 3'b000, 32'hCAFE0001, 32'h0, 32'h90);
        total++;
        if ({reg_wr, wr_reg, wr_data} !== {1'b1, 5'd6, 32'hCAFE0001}) begin
            bad++; $display("FAIL sel11_write: got we=%0b rd=%0d data=%h required we=1 rd=6 data=cafe0001", reg_wr, wr_reg, wr_data);
        end
        total++;
        if (instret !== 64'd2) begin
            bad++; $display("FAIL alu_jal_instret: got=%0d required=2", instret);
        end
        exp_cnt++;
    endtask

    task automatic test_loads();
        logic [2:0]  f3  [8];
        logic [31:0] adr [8];
        logic [31:0] exp [8];
        f3[0] = 3'b000; adr[0] = 32'h1001; exp[0] = 32'hFFFFFFA2;
        f3[1] = 3'b100; adr[1] = 32'h1001; exp[1] = 32'h000000A2;
        f3[2] = 3'b001; adr[2] = 32'h1002; exp[2] = 32'hFFFF8091;
        f3[3] = 3'b101; adr[3] = 32'h1002; exp[3] = 32'h00008091;
        f3[4] = 3'b010; adr[4] = 32'h1000; exp[4] = 32'h8091A2F3;
        f3[5] = 3'b000; adr[5] = 32'h1003; exp[5] = 32'hFFFFFF80;
        f3[6] = 3'b100; adr[6] = 32'h1000; exp[6] = 32'h000000F3;
        f3[7] = 3'b001; adr[7] = 32'h1000; exp[7] = 32'hFFFFA2F3;
        // consecutive loads retire one per cycle with no bubbles
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 1'b0, 5'(10 + i), 1'b1, 2'b01, f3[i], adr[i], 32'h8091A2F3, 32'h0);
            total++;
            if ({reg_wr, wr_reg, wr_data, misalign} !== {1'b1, 5'(10 + i), exp[i], 1'b0}) begin
                bad++;
                $display("FAIL load_%0d: got we=%0b rd=%0d data=%h mis=%0b required we=1 rd=%0d data=%h mis=0",
                         i, reg_wr, wr_reg, wr_data, misalign, 10 + i, exp[i]);
            end
            total++;
            if (instret !== exp_cnt) begin
                bad++; $display("FAIL load_instret_%0d: got=%0d required=%0d", i, instret, exp_cnt);
            end
            exp_cnt++;
        end
    endtask

    task automatic test_misalign();
        issue(1'b1, 1'b0, 5'd7, 1'b1, 2'b01, 3'b010, 32'h2003, 32'h11223344, 32'h0);
        total++;
        if ({misalign, reg_wr, fwd_valid} !== 3'b100) begin
            bad++; $display("FAIL lw_misalign: got mis=%0b we=%0b fwd=%0b required mis=1 we=0 fwd=0", misalign, reg_wr, fwd_valid);
        end
        issue(1'b1, 1'b0, 5'd8, 1'b1, 2'b01, 3'b101, 32'h2001, 32'h11223344, 32'h0);
        total++;
        if ({misalign, reg_wr} !== 2'b10) begin
            bad++; $display("FAIL lhu_misalign: got mis=%0b we=%0b required mis=1 we=0", misalign, reg_wr);
        end
        total++;
        if (instret !== exp_cnt) begin
            bad++; $display("FAIL misalign_instret_a: got=%0d required=%0d", instret, exp_cnt);
        end
        bubble();
        total++;
        if ({misalign, reg_wr} !== 2'b00) begin
            bad++; $display("FAIL misalign_pulse: got mis=%0b we=%0b required mis=0 we=0", misalign, reg_wr);
        end
        total++;
        if (instret !== exp_cnt) begin
            bad++; $display("FAIL misalign_instret_b: got=%0d required=%0d", instret, exp_cnt);
        end
    endtask

    task automatic test_x0_flush();
        issue(1'b1, 1'b0, 5'd0, 1'b1, 2'b00, 3'b000, 32'h55, 32'h0, 32'h0);
        total++;
        if (reg_wr !== 1'b0) begin
            bad++; $display("FAIL x0_write: got we=%0b required we=0", reg_wr);
        end
        exp_cnt++;
        issue(1'b1, 1'b1, 5'd4, 1'b1, 2'b00, 3'b000, 32'h66, 32'h0, 32'h0);
        total++;
        if ({reg_wr, wr_reg, wr_data} !== {1'b0, 5'd0, 32'h0}) begin
            bad++; $display("FAIL flush_write: got we=%0b rd=%0d data=%h required all zero", reg_wr, wr_reg, wr_data);
        end
        total++;
        if (instret !== exp_cnt) begin
            bad++; $display("FAIL x0_instret: got=%0d required=%0d", instret, exp_cnt);
        end
        // a store retires without writing but still shows its rd/data
        issue(1'b1, 1'b0, 5'd3, 1'b0, 2'b00, 3'b010, 32'h77, 32'h0, 32'h0);
        total++;
        if ({reg_wr, wr_reg, wr_data} !== {1'b0, 5'd3, 32'h77}) begin
            bad++; $display("FAIL store_nowrite: got we=%0b rd=%0d data=%h required we=0 rd=3 data=00000077", reg_wr, wr_reg, wr_data);
        end
        total++;
        if (instret !== exp_cnt) begin
            bad++; $display("FAIL flush_instret: got=%0d required=%0d", instret, exp_cnt);
        end
        exp_cnt++;
        bubble();
        total++;
        if (instret !== exp_cnt) begin
            bad++; $display("FAIL store_instret: got=%0d required=%0d", instret, exp_cnt);
        end
    endtask

    task automatic test_midstream_reset();
        issue(1'b1, 1'b0, 5'd9, 1'b1, 2'b01, 3'b010, 32'h3000, 32'hA5A5A5A5, 32'h0);
        total++;
        if ({reg_wr, wr_data} !== {1'b1, 32'hA5A5A5A5}) begin
            bad++; $display("FAIL pre_reset_load: got we=%0b data=%h required we=1 data=a5a5a5a5", reg_wr, wr_data);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({reg_wr, wr_reg, wr_data, fwd_valid, fwd_rd, fwd_data, misalign} !== 72'h0) begin
            bad++; $display("FAIL async_reset_outputs: got we=%0b rd=%0d data=%h required all zero", reg_wr, wr_reg, wr_data);
        end
        total++;
        if (instret !== 64'h0) begin
            bad++; $display("FAIL async_reset_instret: got=%0d required=0", instret);
        end
        @(posedge clk);
        #1;
        total++;
        if ({reg_wr, instret} !== 65'h0) begin
            bad++; $display("FAIL reset_hold: got we=%0b instret=%0d required we=0 instret=0", reg_wr, instret);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_valid = 1'b0;
        exp_cnt = 64'h0;
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.instret_reg = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_reg;
        #1;
        total++;
        if (instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            bad++; $display("FAIL wrap_preload: got=%h required=ffffffffffffffff", instret);
        end
        issue(1'b1, 1'b0, 5'd2, 1'b1, 2'b00, 3'b000, 32'h1, 32'h0, 32'h0);
        bubble();
        total++;
        if (instret !== 64'h0) begin
            bad++; $display("FAIL wrap: got=%h required=0000000000000000", instret);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_cnt = 64'h0;
        test_reset();
        test_alu_jal();
        test_loads();
        test_misalign();
        test_x0_flush();
        test_midstream_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, required completion before 100us");
        $fatal(1);
    end

endmodule
